fpu_addsub_sched: RTL and testbench
===================================

# fpu_addsub_sched

Sequencing and arbitration controller for the single-precision floating-point add/sub datapath. Two requesters share one datapath instance. The block arbitrates round-robin, registers the winner's operands, holds them stable on the datapath for a fixed settle window, then captures result and exception flags into a response register with valid/ready backpressure. It also keeps sticky exception flags for software.

## Interface
- `SETTLE_CYCLES`, default 2: cycles the combinational datapath is given before capture; legal range 1..15.
- `clk` in 1: single clock; all state on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req0_valid` / `req1_valid` in 1: request present.
- `req0_ready` / `req1_ready` out 1: request accepted on the edge where valid & ready.
- `req0_a`, `req0_b` / `req1_a`, `req1_b` in 32: IEEE-754 operands {S, E[7:0], M[22:0]}.
- `req0_sub` / `req1_sub` in 1: 1 means a−b, 0 means a+b.
- `req0_rm` / `req1_rm` in 2: rounding mode, passed through.
- `dp_a`, `dp_b` out 32: registered operands to the datapath.
- `dp_sub` out 1: registered op.
- `dp_eop` out 1: effective operation, `op_sub ^ a[31] ^ b[31]`.
- `dp_rm` out 2: registered rounding mode.
- `dp_z` in 32: datapath result {Sz, Ez, Mz}.
- `dp_flags` in 5: {invalid, overflow, underflow, inexact, zero}.
- `rsp_valid` out 1: response available.
- `rsp_ready` in 1: consumer accepts the response.
- `rsp_id` out 1: requester index of the response.
- `rsp_z` out 32: captured result.
- `rsp_flags` out 5: captured flags.
- `sticky_flags` out 5: OR of `rsp_flags` since reset or the last clear.
- `clr_flags` in 1: synchronous clear of `sticky_flags`.

## Operation
- FSM has 3 states: IDLE, BUSY, RESP.
- **IDLE**
  - `reqN_ready` = IDLE & `reqN_valid` & (other not valid | `ptr` == N). The only comb path is valid→ready.
  - On accept, register a, b, sub, rm and id; `ptr` ← id ^ 1; `cnt` ← SETTLE_CYCLES−1; go to BUSY.
- **BUSY**
  - `dp_*` are driven from the registers and held constant.
  - `cnt` decrements each cycle.
  - At the edge where `cnt` == 0: `rsp_z` ← `dp_z`, `rsp_flags` ← `dp_flags`, `sticky_flags` |= `dp_flags`; go to RESP.
- **RESP**
  - `rsp_valid` = 1.
  - `rsp_z`, `rsp_flags` and `rsp_id` stay stable until the edge where `rsp_ready` = 1; then go to IDLE.
  - Both requester readies are low.
- `dp_*` registers keep their last values outside BUSY. The datapath output is ignored except at the capture edge.
- Round-robin: `ptr` flips only on accept. A lone valid requester is granted regardless of `ptr`.
- If `clr_flags` and a capture occur on the same edge, `sticky_flags` ← `dp_flags` (clear first, then set).
- If `clr_flags` occurs without a capture, `sticky_flags` ← 0.
- A requester deasserting valid before ready has no effect. No abort exists.

## Timing
- Reset values:
  - state IDLE, `ptr` = 0, `cnt` = 0.
  - All registered outputs are 0: `dp_a`, `dp_b`, `dp_sub`, `dp_eop`, `dp_rm`, `rsp_valid`, `rsp_id`, `rsp_z`, `rsp_flags`, `sticky_flags`.
- Reset mid-operation (BUSY or RESP): the operation is dropped and no response is produced. The next accept is possible in the first cycle after `rst` deasserts.
- Latency:
  - Accept at edge E0.
  - Capture at edge E0+SETTLE_CYCLES.
  - `rsp_valid` is high starting the cycle after that capture edge.
- Throughput: with `rsp_ready` held at 1, one op per SETTLE_CYCLES+2 cycles (accept, settle, response handshake, IDLE).
- `reqN_ready` is never high while `rsp_valid` is high.
- An accept and a response handshake never occur on the same edge.

## Test plan
- **Single op:** req0 a=0x3F800000, b=0x40000000, sub=0 (1.0+2.0), SETTLE_CYCLES=2, `rsp_ready`=1.
  - `rsp_valid` rises 2 cycles after the accept edge.
  - `rsp_z`=0x40400000, `rsp_id`=0, `rsp_flags`=0.
- **Effective operation:** req1 a=0x40400000, b=0xBF800000, sub=1 (3.0−(−1.0)).
  - `dp_eop`=0 during BUSY.
  - `rsp_z`=0x40800000, `rsp_id`=1.
- **Contention after reset:** both valid continuously with 2 ops each.
  - Grants go 0,1,0,1.
  - `rsp_id` sequence is 0,1,0,1; accepts are exactly 4 cycles apart.
- **Backpressure:** hold `rsp_ready`=0 for 5 cycles during RESP with req1 valid.
  - `rsp_z`, `rsp_flags` and `rsp_id` are unchanged throughout; both readies stay 0.
  - req1 is accepted in the first IDLE cycle after the handshake.
- **Sticky flags:** 0x7F7FFFFF+0x7F7FFFFF.
  - `rsp_flags[3]` (overflow)=1; `sticky_flags`=5'b01010.
  - A following 1.0+2.0 leaves `sticky_flags` unchanged.
  - `clr_flags` on the next op's capture edge leaves `sticky_flags`=`rsp_flags` of that op.
- **Reset in BUSY:** assert `rst` 1 cycle after accept.
  - All outputs go to 0 immediately (asynchronously); no `rsp_valid` appears afterwards.
  - `ptr`=0, so with both requesters valid req0 wins next.

Source files
------------

// File: rtl/fpu_addsub_sched.sv
`timescale 1ns/1ps
// Round-robin scheduler for a shared single-precision add/sub datapath:
// registers the winning request, waits out the settle window, then holds the result for the consumer.
//
// state | meaning
// IDLE  | arbitrating; requester readies follow valids
// BUSY  | operands held on the datapath while the settle counter runs down
// RESP  | captured result offered to the consumer until rsp_ready
module fpu_addsub_sched #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req0_sub,
  input  logic [1:0]  req0_rm,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic        req1_sub,
  input  logic [1:0]  req1_rm,
  output logic [31:0] dp_a,
  output logic [31:0] dp_b,
  output logic        dp_sub,
  output logic        dp_eop,
  output logic [1:0]  dp_rm,
  input  logic [31:0] dp_z,
  input  logic [4:0]  dp_flags,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_z,
  output logic [4:0]  rsp_flags,
  output logic [4:0]  sticky_flags,
  input  logic        clr_flags
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_t;

  localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

  state_t      state, state_nxt;
  logic        ptr, id_q;
  logic        grant0, grant1, accept, capture;
  logic [3:0]  cnt;
  logic [31:0] sel_a, sel_b;
  logic        sel_sub;
  logic [1:0]  sel_rm;
  logic [4:0]  sticky_base;

  // A lone requester wins regardless of ptr; ptr only breaks ties.
  always_comb begin
    grant0  = (state == IDLE) && req0_valid && (!req1_valid || !ptr);
    grant1  = (state == IDLE) && req1_valid && (!req0_valid || ptr);
    accept  = grant0 || grant1;
    capture = (state == BUSY) && (cnt == 4'd0);
    sel_a   = grant1 ? req1_a : req0_a;
    sel_b   = grant1 ? req1_b : req0_b;
    sel_sub = grant1 ? req1_sub : req0_sub;
    sel_rm  = grant1 ? req1_rm : req0_rm;
  end

  assign req0_ready  = grant0;
  assign req1_ready  = grant1;
  assign rsp_valid   = (state == RESP);
  assign sticky_base = clr_flags ? 5'd0 : sticky_flags;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = BUSY;
      BUSY:    if (cnt == 4'd0) state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= 1'b0;
      cnt   <= 4'd0;
      id_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        ptr  <= ~grant1;
        id_q <= grant1;
        cnt  <= CNT_INIT;
      end else if ((state == BUSY) && (cnt != 4'd0)) begin
        cnt <= cnt - 4'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dp_a   <= 32'd0;
      dp_b   <= 32'd0;
      dp_sub <= 1'b0;
      dp_eop <= 1'b0;
      dp_rm  <= 2'd0;
    end else if (accept) begin
      dp_a   <= sel_a;
      dp_b   <= sel_b;
      dp_sub <= sel_sub;
      dp_eop <= sel_sub ^ sel_a[31] ^ sel_b[31];
      dp_rm  <= sel_rm;
    end
  end

  // Clear applies before the newly captured flags are merged in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_id       <= 1'b0;
      rsp_z        <= 32'd0;
      rsp_flags    <= 5'd0;
      sticky_flags <= 5'd0;
    end else if (capture) begin
      rsp_id       <= id_q;
      rsp_z        <= dp_z;
      rsp_flags    <= dp_flags;
      sticky_flags <= sticky_base | dp_flags;
    end else if (clr_flags) begin
      sticky_flags <= 5'd0;
    end
  end

endmodule

// File: tb/tb_fpu_addsub_sched.sv
`timescale 1ns/1ps
// Directed bench for fpu_addsub_sched; a lookup-table datapath model answers the
// operand pairs used by the scenarios.
module tb_fpu_addsub_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic        req0_sub = 1'b0, req1_sub = 1'b0;
  logic [1:0]  req0_rm = '0, req1_rm = '0;
  logic [31:0] dp_a, dp_b, dp_z;
  logic        dp_sub, dp_eop;
  logic [1:0]  dp_rm;
  logic [4:0]  dp_flags;
  logic        rsp_valid, rsp_id;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_z;
  logic [4:0]  rsp_flags, sticky_flags;
  logic        clr_flags = 1'b0;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int acc_id[$];
  int acc_cyc[$];
  int rsp_ids[$];
  logic [31:0] rsp_zs[$];

  fpu_addsub_sched #(.SETTLE_CYCLES(2)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_sub(req0_sub), .req0_rm(req0_rm),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_sub(req1_sub), .req1_rm(req1_rm),
    .dp_a(dp_a), .dp_b(dp_b), .dp_sub(dp_sub), .dp_eop(dp_eop), .dp_rm(dp_rm),
    .dp_z(dp_z), .dp_flags(dp_flags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_z(rsp_z),
    .rsp_flags(rsp_flags), .sticky_flags(sticky_flags), .clr_flags(clr_flags)
  );

  always #5 clk = ~clk;

  function automatic logic [36:0] dp_model(input logic sub, input logic [31:0] a, input logic [31:0] b);
    case ({sub, a, b})
      {1'b0, 32'h3F800000, 32'h40000000}: return {32'h40400000, 5'b00000};
      {1'b1, 32'h40400000, 32'hBF800000}: return {32'h40800000, 5'b00000};
      {1'b0, 32'h40400000, 32'h3F800000}: return {32'h40800000, 5'b00000};
      {1'b0, 32'h3F800000, 32'h3F800000}: return {32'h40000000, 5'b00000};
      {1'b1, 32'h40800000, 32'h3F800000}: return {32'h40400000, 5'b00000};
      {1'b0, 32'h7F7FFFFF, 32'h7F7FFFFF}: return {32'h7F800000, 5'b01010};
      {1'b0, 32'h3F800000, 32'h33800000}: return {32'h3F800000, 5'b00010};
      default:                            return {32'hDEADBEEF, 5'b10000};
    endcase
  endfunction

  always_comb {dp_z, dp_flags} = dp_model(dp_sub, dp_a, dp_b);

  always @(posedge clk) begin
    if (!rst) begin
      if (req0_valid && req0_ready) begin acc_id.push_back(0); acc_cyc.push_back(cyc); end
      if (req1_valid && req1_ready) begin acc_id.push_back(1); acc_cyc.push_back(cyc); end
      if (rsp_valid && rsp_ready) begin rsp_ids.push_back(int'(rsp_id)); rsp_zs.push_back(rsp_z); end
    end
    cyc++;
  end

  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if ((req0_ready || req1_ready) && rsp_valid) begin
        errors++;
        $display("FAIL ready_vs_rsp_valid: ready0=%b ready1=%b rsp_valid=%b, required no ready while rsp_valid",
                 req0_ready, req1_ready, rsp_valid);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input bit id, input logic [31:0] a, input logic [31:0] b,
                       input logic sub, input logic [1:0] rm);
    bit ok = 1'b0;
    if (id == 1'b0) begin req0_a = a; req0_b = b; req0_sub = sub; req0_rm = rm; req0_valid = 1'b1; end
    else            begin req1_a = a; req1_b = b; req1_sub = sub; req1_rm = rm; req1_valid = 1'b1; end
    for (int n = 0; n < 20 && !ok; n++) begin
      #1;
      ok = (id == 1'b0) ? req0_ready : req1_ready;
      tick();
    end
    if (id == 1'b0) req0_valid = 1'b0; else req1_valid = 1'b0;
    checks++;
    if (!ok) begin errors++; $display("FAIL accept_timeout: req%0d ready=0, required 1 within 20 cycles", id); end
  endtask

  task automatic wait_rsp();
    bit seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      if (rsp_valid) seen = 1'b1; else tick();
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL rsp_timeout: rsp_valid=0, required 1 within 20 cycles"); end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    #3 rst = 1'b1;
    #2;
    checks++;
    if ({dp_a, dp_b, dp_sub, dp_eop, dp_rm} !== 68'd0) begin
      errors++; $display("FAIL reset_dp: dp_a=%h dp_b=%h sub=%b eop=%b rm=%b, required all 0", dp_a, dp_b, dp_sub, dp_eop, dp_rm);
    end
    checks++;
    if ({rsp_valid, rsp_id, rsp_z, rsp_flags, sticky_flags} !== 44'd0) begin
      errors++; $display("FAIL reset_rsp: valid=%b id=%b z=%h flags=%b sticky=%b, required all 0", rsp_valid, rsp_id, rsp_z, rsp_flags, sticky_flags);
    end
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_single_op();
    rsp_ready = 1'b1;
    do_op(1'b0, 32'h3F800000, 32'h40000000, 1'b0, 2'b10);
    checks++;
    if (dp_a !== 32'h3F800000 || dp_b !== 32'h40000000 || dp_rm !== 2'b10) begin
      errors++; $display("FAIL single_dp: a=%h b=%h rm=%b, required 3f800000 40000000 10", dp_a, dp_b, dp_rm);
    end
    checks++;
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_early0: rsp_valid=%b, required 0", rsp_valid); end
    tick();
    checks++;
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_early1: rsp_valid=%b, required 0", rsp_valid); end
    tick();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_z !== 32'h40400000 || rsp_id !== 1'b0 || rsp_flags !== 5'd0) begin
      errors++; $display("FAIL single_rsp: valid=%b z=%h id=%b flags=%b, required 1 40400000 0 00000", rsp_valid, rsp_z, rsp_id, rsp_flags);
    end
    tick();
    checks++;
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_done: rsp_valid=%b, required 0", rsp_valid); end
  endtask

  task automatic test_eop();
    do_op(1'b1, 32'h40400000, 32'hBF800000, 1'b1, 2'b00);
    checks++;
    if (dp_eop !== 1'b0 || dp_sub !== 1'b1) begin
      errors++; $display("FAIL eop_busy: eop=%b sub=%b, required 0 1", dp_eop, dp_sub);
    end
    tick();
    tick();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_z !== 32'h40800000 || rsp_id !== 1'b1) begin
      errors++; $display("FAIL eop_rsp: valid=%b z=%h id=%b, required 1 40800000 1", rsp_valid, rsp_z, rsp_id);
    end
    tick();
  endtask

  task automatic test_contention();
    int n0 = 0, n1 = 0, prev;
    logic [31:0] exp_z[4] = '{32'h40400000, 32'h40000000, 32'h40800000, 32'h40400000};
    apply_reset();
    acc_id.delete(); acc_cyc.delete(); rsp_ids.delete(); rsp_zs.delete();
    rsp_ready = 1'b1;
    req0_a = 32'h3F800000; req0_b = 32'h40000000; req0_sub = 1'b0;
    req1_a = 32'h3F800000; req1_b = 32'h3F800000; req1_sub = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int n = 0; n < 60 && rsp_ids.size() < 4; n++) begin
      prev = acc_id.size();
      tick();
      if (acc_id.size() != prev) begin
        if (acc_id[prev] == 0) begin
          n0++; req0_a = 32'h40400000; req0_b = 32'h3F800000;
          if (n0 == 2) req0_valid = 1'b0;
        end else begin
          n1++; req1_a = 32'h40800000; req1_b = 32'h3F800000; req1_sub = 1'b1;
          if (n1 == 2) req1_valid = 1'b0;
        end
      end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    checks++;
    if (acc_id.size() != 4 || rsp_ids.size() != 4) begin
      errors++; $display("FAIL cont_count: accepts=%0d responses=%0d, required 4 4", acc_id.size(), rsp_ids.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (acc_id[i] != (i % 2) || rsp_ids[i] != (i % 2) || rsp_zs[i] !== exp_z[i]) begin
          errors++; $display("FAIL cont_order[%0d]: grant=%0d rsp_id=%0d z=%h, required %0d %0d %h",
                             i, acc_id[i], rsp_ids[i], rsp_zs[i], i % 2, i % 2, exp_z[i]);
        end
        if (i > 0) begin
          checks++;
          if (acc_cyc[i] - acc_cyc[i-1] != 4) begin
            errors++; $display("FAIL cont_spacing[%0d]: gap=%0d, required 4", i, acc_cyc[i] - acc_cyc[i-1]);
          end
        end
      end
    end
  endtask

  task automatic test_backpressure();
    rsp_ready = 1'b0;
    do_op(1'b0, 32'h3F800000, 32'h40000000, 1'b0, 2'b00);
    req1_a = 32'h3F800000; req1_b = 32'h3F800000; req1_sub = 1'b0; req1_valid = 1'b1;
    wait_rsp();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (rsp_valid !== 1'b1 || rsp_z !== 32'h40400000 || rsp_flags !== 5'd0 || rsp_id !== 1'b0 ||
          req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
        errors++; $display("FAIL bp_hold[%0d]: valid=%b z=%h flags=%b id=%b r0=%b r1=%b, required 1 40400000 00000 0 0 0",
                           i, rsp_valid, rsp_z, rsp_flags, rsp_id, req0_ready, req1_ready);
      end
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    checks++;
    if (rsp_valid !== 1'b0 || req1_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release: rsp_valid=%b req1_ready=%b, required 0 1", rsp_valid, req1_ready);
    end
    tick();
    req1_valid = 1'b0;
    checks++;
    if (dp_a !== 32'h3F800000 || dp_b !== 32'h3F800000) begin
      errors++; $display("FAIL bp_accept: dp_a=%h dp_b=%h, required 3f800000 3f800000", dp_a, dp_b);
    end
    wait_rsp();
    checks++;
    if (rsp_z !== 32'h40000000 || rsp_id !== 1'b1) begin
      errors++; $display("FAIL bp_second: z=%h id=%b, required 40000000 1", rsp_z, rsp_id);
    end
    tick();
  endtask

  task automatic test_sticky();
    rsp_ready = 1'b1;
    do_op(1'b0, 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 2'b00);
    wait_rsp();
    checks++;
    if (rsp_z !== 32'h7F800000 || rsp_flags !== 5'b01010 || sticky_flags !== 5'b01010) begin
      errors++; $display("FAIL sticky_ovf: z=%h flags=%b sticky=%b, required 7f800000 01010 01010", rsp_z, rsp_flags, sticky_flags);
    end
    tick();
    do_op(1'b0, 32'h3F800000, 32'h40000000, 1'b0, 2'b00);
    wait_rsp();
    checks++;
    if (sticky_flags !== 5'b01010) begin
      errors++; $display("FAIL sticky_keep: sticky=%b, required 01010", sticky_flags);
    end
    tick();
    do_op(1'b0, 32'h3F800000, 32'h33800000, 1'b0, 2'b00);
    tick();
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_flags !== 5'b00010 || sticky_flags !== 5'b00010) begin
      errors++; $display("FAIL sticky_clr_cap: valid=%b flags=%b sticky=%b, required 1 00010 00010", rsp_valid, rsp_flags, sticky_flags);
    end
    tick();
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    checks++;
    if (sticky_flags !== 5'b00000) begin
      errors++; $display("FAIL sticky_clr_idle: sticky=%b, required 00000", sticky_flags);
    end
  endtask

  task automatic test_reset_busy();
    rsp_ready = 1'b1;
    do_op(1'b0, 32'h3F800000, 32'h40000000, 1'b0, 2'b11);
    tick();
    rst = 1'b1;
    #1;
    checks++;
    if ({dp_a, dp_b, dp_sub, dp_eop, dp_rm, rsp_valid, rsp_id, rsp_z, rsp_flags, sticky_flags} !== 112'd0) begin
      errors++; $display("FAIL rst_busy_async: dp_a=%h dp_rm=%b rsp_valid=%b rsp_z=%h, required all 0", dp_a, dp_rm, rsp_valid, rsp_z);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_busy_norsp[%0d]: rsp_valid=%b, required 0", i, rsp_valid); end
    end
    rst = 1'b0;
    req0_a = 32'h3F800000; req0_b = 32'h40000000; req0_sub = 1'b0; req0_rm = 2'b00;
    req1_a = 32'h3F800000; req1_b = 32'h3F800000; req1_sub = 1'b0; req1_rm = 2'b00;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL rst_busy_ptr: r0=%b r1=%b rsp_valid=%b, required 1 0 0", req0_ready, req1_ready, rsp_valid);
    end
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    checks++;
    if (dp_a !== 32'h3F800000 || dp_b !== 32'h40000000) begin
      errors++; $display("FAIL rst_busy_accept: dp_a=%h dp_b=%h, required 3f800000 40000000", dp_a, dp_b);
    end
    wait_rsp();
    checks++;
    if (rsp_id !== 1'b0 || rsp_z !== 32'h40400000) begin
      errors++; $display("FAIL rst_busy_rsp: id=%b z=%h, required 0 40400000", rsp_id, rsp_z);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_single_op();
    test_eop();
    test_contention();
    test_backpressure();
    test_sticky();
    test_reset_busy();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
